// File: rtl/aib_sr_pkg.sv
// Purpose:      shared defaults and FSM encoding for the AIB sideband receive path.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
package aib_sr_pkg;

  // Default geometry of the master sideband word and its qualification rules
  localparam int AIB_SR_MS_LENGTH = 81;
  localparam int AIB_SR_MATCH_CNT = 2;
  localparam int AIB_SR_TMO_CYC   = 328;

  // Gap counter width; covers the largest supported timeout (1023)
  localparam int AIB_SR_GAP_W = 10;

  // Receive qualifier FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_LOST   = 2'd3;

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/aib_sr_ms_rx_qual.sv
// Purpose:      qualifies the received master sideband word: a frame must repeat
//               MATCH_CNT times at the correct spacing before it reaches the core.
// Latency:      ms_rx_data_q/ms_rx_valid/ms_rx_upd move 2 clocks after the qualifying load.
// Backpressure: none; the sideband is free-running and every frame is consumed.
//
// Ports:
//   sr_ms_clk_in     forwarded sideband clock
//   osc_fsm_sl_rstn  asynchronous active-low reset
//   sr_ms_load_in    frame load strobe from the link
//   ms_data_to_core  word captured by the serial receiver on the last load
//   ms_rx_data_q     qualified word (holds its value across link loss)
//   ms_rx_valid      qualified word is trustworthy (LOCKED)
//   ms_rx_upd        one-cycle pulse when ms_rx_data_q takes a new value
//   ms_rx_timeout    link lost (LOST)
//   ms_rx_frm_err    saturating count of frames with bad spacing
module aib_sr_ms_rx_qual
  import aib_sr_pkg::*;
#(
  parameter int MS_LENGTH = AIB_SR_MS_LENGTH,
  parameter int MATCH_CNT = AIB_SR_MATCH_CNT,
  parameter int TMO_CYC   = AIB_SR_TMO_CYC
) (
  input  logic                 sr_ms_clk_in,
  input  logic                 osc_fsm_sl_rstn,
  input  logic                 sr_ms_load_in,
  input  logic [MS_LENGTH-1:0] ms_data_to_core,
  output logic [MS_LENGTH-1:0] ms_rx_data_q,
  output logic                 ms_rx_valid,
  output logic                 ms_rx_upd,
  output logic                 ms_rx_timeout,
  output logic [7:0]           ms_rx_frm_err
);

  localparam logic [AIB_SR_GAP_W-1:0] EXP_GAP = AIB_SR_GAP_W'(MS_LENGTH + 1);
  localparam logic [AIB_SR_GAP_W-1:0] TMO_LIM = AIB_SR_GAP_W'(TMO_CYC);
  localparam logic [2:0]              MATCH_C = 3'(MATCH_CNT);

  logic                    load_d1;
  logic [1:0]              state, state_nxt;
  logic [AIB_SR_GAP_W-1:0] gap_cnt, gap_nxt;
  logic [2:0]              match_cnt, match_nxt;
  logic [MS_LENGTH-1:0]    prev_cand;
  logic                    qual_pend;

  logic frame_evt;
  logic unchecked;
  logic spacing_err;
  logic accept;
  logic same_cand;
  logic tmo_hit;
  logic qual_hit;

  // The receiver's word is valid in the cycle after the load strobe
  assign frame_evt = load_d1;

  // First frame after reset or after loss has no reference to be spaced against
  assign unchecked   = (state == ST_IDLE) || (state == ST_LOST);
  assign spacing_err = frame_evt && !unchecked && (gap_cnt != EXP_GAP);
  assign accept      = frame_evt && !spacing_err;
  assign same_cand   = (ms_data_to_core == prev_cand);

  // Gap counter restarts on any frame event and sticks at the timeout limit
  always_comb begin
    gap_nxt = gap_cnt;
    if (frame_evt) begin
      gap_nxt = AIB_SR_GAP_W'(1);
    end else if (gap_cnt != TMO_LIM) begin
      gap_nxt = gap_cnt + AIB_SR_GAP_W'(1);
    end
  end

  // A frame event in the expiry cycle wins because it forces gap_nxt back to 1
  assign tmo_hit = !frame_evt && (gap_nxt == TMO_LIM) &&
                   ((state == ST_ACQ) || (state == ST_LOCKED));

  always_comb begin
    match_nxt = match_cnt;
    if (spacing_err) begin
      match_nxt = 3'd0;
    end else if (accept) begin
      if (!same_cand) begin
        match_nxt = 3'd1;
      end else if (match_cnt < MATCH_C) begin
        match_nxt = match_cnt + 3'd1;
      end
    end
    // Clearing on loss lets the same word requalify after the link returns
    if (tmo_hit) begin
      match_nxt = 3'd0;
    end
  end

  // Qualify only on the frame that brings the count up to MATCH_CNT; with a
  // threshold of one every accepted frame qualifies.
  assign qual_hit = accept && (match_nxt == MATCH_C) &&
                    ((match_cnt != MATCH_C) || (MATCH_CNT == 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_evt) state_nxt = ST_ACQ;
      ST_ACQ: begin
        if (tmo_hit)        state_nxt = ST_LOST;
        else if (qual_pend) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: if (tmo_hit)   state_nxt = ST_LOST;
      ST_LOST:   if (frame_evt) state_nxt = ST_ACQ;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sr_ms_clk_in or negedge osc_fsm_sl_rstn) begin
    if (!osc_fsm_sl_rstn) begin
      load_d1       <= 1'b0;
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      match_cnt     <= '0;
      prev_cand     <= '0;
      qual_pend     <= 1'b0;
      ms_rx_data_q  <= '0;
      ms_rx_upd     <= 1'b0;
      ms_rx_frm_err <= '0;
    end else begin
      load_d1   <= sr_ms_load_in;
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      match_cnt <= match_nxt;
      qual_pend <= qual_hit;
      if (accept) begin
        prev_cand <= ms_data_to_core;
      end
      if (spacing_err) begin
        ms_rx_frm_err <= sat_inc8(ms_rx_frm_err);
      end
      // prev_cand already holds the qualifying word one cycle after the match
      if (qual_pend) begin
        ms_rx_data_q <= prev_cand;
      end
      ms_rx_upd <= qual_pend && ((state != ST_LOCKED) || (prev_cand != ms_rx_data_q));
    end
  end

  assign ms_rx_valid   = (state == ST_LOCKED);
  assign ms_rx_timeout = (state == ST_LOST);

endmodule
